// File: rtl/alu_seq_control.sv
// alu_seq_control: decodes R-type function codes into registered per-unit
// operation selects and sequences the multi-cycle MULTU/DIVU operations.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   funct    - R-type function code, sampled only when start=1
//   start    - qualifies funct
//   flush    - synchronous abort of a multi-cycle op; suppresses start
//   sel_alu  - ALU operation select (registered)
//   sel_sht  - shifter operation select (registered)
//   sel_mul  - multiplier operation select (registered)
//   sel_div  - divider operation select (registered)
//   sel_mux  - result mux select (registered)
//   busy     - multi-cycle op in progress (registered)
//   done     - one-cycle completion pulse (registered)
//   hilo_we  - HI/LO write enable, high only in the DONE cycle (registered)
//   stall    - start arriving while busy (combinational)
module alu_seq_control #(
    parameter int unsigned MUL_CYCLES = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] funct,
    input  logic       start,
    input  logic       flush,
    output logic [5:0] sel_alu,
    output logic [5:0] sel_sht,
    output logic [5:0] sel_mul,
    output logic [5:0] sel_div,
    output logic [5:0] sel_mux,
    output logic       busy,
    output logic       done,
    output logic       hilo_we,
    output logic       stall
);

    localparam logic [5:0] FnAnd   = 6'd36;
    localparam logic [5:0] FnOr    = 6'd37;
    localparam logic [5:0] FnAdd   = 6'd32;
    localparam logic [5:0] FnSub   = 6'd34;
    localparam logic [5:0] FnSlt   = 6'd42;
    localparam logic [5:0] FnSrl   = 6'd2;
    localparam logic [5:0] FnMultu = 6'd25;
    localparam logic [5:0] FnDivu  = 6'd27;
    localparam logic [5:0] FnMfhi  = 6'd16;
    localparam logic [5:0] FnMflo  = 6'd18;
    localparam logic [5:0] FnOut   = 6'd63;

    // Counter value on the last cycle of each multi-cycle op.
    localparam logic [7:0] MulLast = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DivLast = 8'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t     state;
    logic [7:0] cnt;

    assign stall = start & busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            cnt     <= 8'd0;
            sel_alu <= 6'd0;
            sel_sht <= 6'd0;
            sel_mul <= 6'd0;
            sel_div <= 6'd0;
            sel_mux <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hilo_we <= 1'b0;
        end else begin
            // Outputs fall back to NOP unless a branch below drives them.
            sel_alu <= 6'd0;
            sel_sht <= 6'd0;
            sel_mul <= 6'd0;
            sel_div <= 6'd0;
            sel_mux <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hilo_we <= 1'b0;
            case (state)
                // DONE accepts a new op exactly like IDLE.
                StIdle, StDone: begin
                    state <= StIdle;
                    if (start && !flush) begin
                        case (funct)
                            FnAnd, FnOr, FnAdd, FnSub, FnSlt: begin
                                sel_alu <= funct;
                                sel_mux <= funct;
                            end
                            FnSrl: begin
                                sel_sht <= FnSrl;
                                sel_mux <= FnSrl;
                            end
                            FnMfhi, FnMflo: begin
                                sel_mux <= funct;
                            end
                            FnMultu: begin
                                state   <= StMul;
                                cnt     <= 8'd0;
                                sel_mul <= FnMultu;
                                sel_mux <= FnMultu;
                                busy    <= 1'b1;
                            end
                            FnDivu: begin
                                state   <= StDiv;
                                cnt     <= 8'd0;
                                sel_div <= FnDivu;
                                sel_mux <= FnDivu;
                                busy    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    if (flush) begin
                        state <= StIdle;
                    end else if (cnt == MulLast) begin
                        state   <= StDone;
                        sel_mux <= FnOut;
                        done    <= 1'b1;
                        hilo_we <= 1'b1;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        sel_mul <= FnMultu;
                        sel_mux <= FnMultu;
                        busy    <= 1'b1;
                    end
                end
                StDiv: begin
                    if (flush) begin
                        state <= StIdle;
                    end else if (cnt == DivLast) begin
                        state   <= StDone;
                        sel_mux <= FnOut;
                        done    <= 1'b1;
                        hilo_we <= 1'b1;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        sel_div <= FnDivu;
                        sel_mux <= FnDivu;
                        busy    <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_control.sv
// Directed bench for alu_seq_control (MUL_CYCLES=32, DIV_CYCLES=4).
module tb_alu_seq_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] funct = 6'd0;
    logic       start = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] sel_alu, sel_sht, sel_mul, sel_div, sel_mux;
    logic       busy, done, hilo_we, stall;

    int total = 0;
    int bad = 0;

    alu_seq_control #(
        .MUL_CYCLES(32),
        .DIV_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .funct  (funct),
        .start  (start),
        .flush  (flush),
        .sel_alu(sel_alu),
        .sel_sht(sel_sht),
        .sel_mul(sel_mul),
        .sel_div(sel_div),
        .sel_mux(sel_mux),
        .busy   (busy),
        .done   (done),
        .hilo_we(hilo_we),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       flush;
        logic [5:0] funct;
        logic [5:0] e_alu;
        logic [5:0] e_sht;
        logic [5:0] e_mux;
    } vec_t;

    vec_t vecs[11];

    // Expected outputs as one word: {alu, sht, mul, div, mux, busy, done, hilo_we}.
    function automatic logic [32:0] pk(input logic [5:0] a, input logic [5:0] s,
                                       input logic [5:0] m, input logic [5:0] d,
                                       input logic [5:0] x, input logic b,
                                       input logic dn, input logic h);
        return {a, s, m, d, x, b, dn, h};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [32:0] exp);
        logic [32:0] act;
        act = {sel_alu, sel_sht, sel_mul, sel_div, sel_mux, busy, done, hilo_we};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    localparam logic [32:0] Zero   = 33'd0;
    localparam logic [32:0] MulOut = {6'd0, 6'd0, 6'd25, 6'd0, 6'd25, 1'b1, 1'b0, 1'b0};
    localparam logic [32:0] DivOut = {6'd0, 6'd0, 6'd0, 6'd27, 6'd27, 1'b1, 1'b0, 1'b0};
    localparam logic [32:0] DoneOut = {6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 1'b0, 1'b1, 1'b1};

    initial begin
        int pulses;

        vecs[0]  = '{1'b1, 1'b0, 6'd32, 6'd32, 6'd0, 6'd32};
        vecs[1]  = '{1'b1, 1'b0, 6'd36, 6'd36, 6'd0, 6'd36};
        vecs[2]  = '{1'b1, 1'b0, 6'd37, 6'd37, 6'd0, 6'd37};
        vecs[3]  = '{1'b1, 1'b0, 6'd34, 6'd34, 6'd0, 6'd34};
        vecs[4]  = '{1'b1, 1'b0, 6'd42, 6'd42, 6'd0, 6'd42};
        vecs[5]  = '{1'b1, 1'b0, 6'd2,  6'd0,  6'd2, 6'd2};
        vecs[6]  = '{1'b1, 1'b0, 6'd16, 6'd0,  6'd0, 6'd16};
        vecs[7]  = '{1'b1, 1'b0, 6'd18, 6'd0,  6'd0, 6'd18};
        vecs[8]  = '{1'b1, 1'b0, 6'd5,  6'd0,  6'd0, 6'd0};
        vecs[9]  = '{1'b0, 1'b0, 6'd32, 6'd0,  6'd0, 6'd0};
        vecs[10] = '{1'b1, 1'b1, 6'd32, 6'd0,  6'd0, 6'd0};

        // Reset state, before any clock edge.
        #2;
        check_outs("reset", Zero);
        check_val("reset_stall", int'(stall), 0);
        tick;
        rst_n = 1'b1;
        tick;

        // Single-cycle decodes from IDLE.
        foreach (vecs[i]) begin
            start = vecs[i].start;
            flush = vecs[i].flush;
            funct = vecs[i].funct;
            tick;
            check_outs($sformatf("vec%0d_f%0d", i, vecs[i].funct),
                       pk(vecs[i].e_alu, vecs[i].e_sht, 6'd0, 6'd0, vecs[i].e_mux,
                          1'b0, 1'b0, 1'b0));
        end
        start = 1'b0;
        flush = 1'b0;
        tick;
        check_outs("idle_nop", Zero);

        // MULTU: 32 busy cycles, then a single DONE cycle.
        start = 1'b1;
        funct = 6'd25;
        tick;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_outs($sformatf("mul_c%0d", i + 1), MulOut);
            tick;
        end
        check_outs("mul_done", DoneOut);
        tick;
        check_outs("mul_after_done", Zero);

        // DIVU with a start while busy (ignored), and a new op issued in DONE.
        start = 1'b1;
        funct = 6'd27;
        tick;
        start = 1'b0;
        check_outs("div_c1", DivOut);
        tick;
        start = 1'b1;
        funct = 6'd36;
        #1;
        check_val("div_stall", int'(stall), 1);
        tick;
        start = 1'b0;
        check_outs("div_c3_ignored", DivOut);
        tick;
        check_outs("div_c4", DivOut);
        tick;
        check_outs("div_done", DoneOut);
        start = 1'b1;
        funct = 6'd36;
        #1;
        check_val("done_no_stall", int'(stall), 0);
        tick;
        start = 1'b0;
        check_outs("and_after_done", pk(6'd36, 6'd0, 6'd0, 6'd0, 6'd36, 1'b0, 1'b0, 1'b0));
        tick;
        check_outs("idle_after_and", Zero);

        // Flush on the 10th MUL cycle.
        start = 1'b1;
        funct = 6'd25;
        tick;
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick;
        check_outs("mul_c10", MulOut);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check_outs("flush_idle", Zero);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || hilo_we) pulses++;
            tick;
        end
        check_val("flush_no_done", pulses, 0);
        start = 1'b1;
        funct = 6'd32;
        tick;
        start = 1'b0;
        check_outs("add_after_flush", pk(6'd32, 6'd0, 6'd0, 6'd0, 6'd32, 1'b0, 1'b0, 1'b0));

        // Flush in the DONE cycle suppresses the start presented with it.
        start = 1'b1;
        funct = 6'd27;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check_outs("div2_done", DoneOut);
        start = 1'b1;
        funct = 6'd32;
        flush = 1'b1;
        tick;
        start = 1'b0;
        flush = 1'b0;
        check_outs("done_flush_suppress", Zero);

        // Asynchronous reset mid-DIV, then a normal MULTU.
        start = 1'b1;
        funct = 6'd27;
        tick;
        start = 1'b0;
        tick;
        check_outs("div_c2_pre_reset", DivOut);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", Zero);
        pulses = 0;
        tick;
        if (done || hilo_we) pulses++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (done || hilo_we) pulses++;
            tick;
        end
        check_val("reset_no_done", pulses, 0);
        start = 1'b1;
        funct = 6'd25;
        tick;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_outs($sformatf("mul2_c%0d", i + 1), MulOut);
            tick;
        end
        check_outs("mul2_done", DoneOut);
        tick;
        check_outs("mul2_after_done", Zero);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_control.md
ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 Parameter MUL_CYCLES, default 32, SHALL set the number of cycles a MULTU operation occupies; legal range 1..255.
REQ-002 Parameter DIV_CYCLES, default 32, SHALL set the number of cycles a DIVU operation occupies; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 funct  input  6  SHALL carry the R-type function code.
REQ-006 start  input  1  SHALL qualify funct; funct is sampled only when start=1.
REQ-007 flush  input  1  SHALL be a synchronous abort of any multi-cycle operation.
REQ-008 sel_alu, sel_sht, sel_mul, sel_div, sel_mux  output  6 each  SHALL be registered per-unit operation selects.
REQ-009 busy  output  1  SHALL be high while a multi-cycle operation is in progress.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking completion of a multi-cycle operation.
REQ-011 hilo_we  output  1  SHALL be the HI/LO write enable, high only in the DONE cycle.
REQ-012 stall  output  1  SHALL be combinational: start AND busy.

Function
REQ-013 Codes: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MULTU=25, DIVU=27, MFHI=16, MFLO=18, OUT=63; any other code (or start=0) SHALL be treated as NOP=0.
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-015 IDLE, start=1, ALU code (AND/OR/ADD/SUB/SLT): next cycle sel_alu=sel_mux=funct, other selects 0; state stays IDLE.
REQ-016 IDLE, start=1, SRL: next cycle sel_sht=sel_mux=2, others 0.
REQ-017 IDLE, start=1, MFHI/MFLO: next cycle sel_mux=funct, others 0.
REQ-018 IDLE, start=1, MULTU: counter cleared, state to MUL; while in MUL sel_mul=sel_mux=25, busy=1.
REQ-019 IDLE, start=1, DIVU: counter cleared, state to DIV; while in DIV sel_div=sel_mux=27, busy=1.
REQ-020 MUL/DIV SHALL last exactly MUL_CYCLES/DIV_CYCLES cycles (counter increments each cycle, exits on count = N-1) then enter DONE.
REQ-021 DONE (one cycle): sel_mux=63, all unit selects 0, done=1, hilo_we=1, busy=0; next state IDLE; a start in the DONE cycle SHALL be accepted as in IDLE.
REQ-022 Latency: start accepted at edge k -> MUL/DIV cycles k+1..k+N, DONE at k+N+1, new op earliest effective k+N+2 (if issued in DONE cycle).
REQ-023 start while busy=1 SHALL be ignored (no state or select change); stall=1 that cycle.
REQ-024 IDLE with start=0 SHALL drive all selects 0.
REQ-025 flush=1 in MUL or DIV SHALL force IDLE next cycle with all selects 0, no done, no hilo_we; flush in IDLE/DONE SHALL suppress that cycle's start; flush has priority over start.
REQ-026 Counter SHALL be 8 bits and never wrap within a legal operation.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, all selects 0, busy=0, done=0, hilo_we=0, regardless of clk.
REQ-028 Reset asserted mid-MUL/DIV SHALL abort without a done or hilo_we pulse; first accepted start is on the first rising edge after rst_n rises.

Verification
REQ-029 Reset then start=1, funct=32 one cycle -> next cycle sel_alu=32, sel_mux=32, others 0, busy=0.
REQ-030 MUL_CYCLES=32, start MULTU at edge k -> busy=1 and sel_mul=25 for 32 cycles, DONE at k+33 with sel_mux=63, done=1, hilo_we=1 for exactly one cycle.
REQ-031 DIV_CYCLES=4, start DIVU, then start=1 funct=36 on cycle 2 -> stall=1, ignored; DONE at cycle 5; funct=36 issued in DONE cycle -> sel_alu=36 next cycle.
REQ-032 flush on 10th MUL cycle -> IDLE next cycle, selects 0, no done/hilo_we pulse ever.
REQ-033 rst_n low asynchronously mid-DIV -> outputs 0 before next clk edge; after release, MULTU start proceeds normally.
REQ-034 start=1, funct=5 (unsupported) -> all selects 0, state IDLE, busy=0.
